// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered ALU with start/done handshake, shift/rotate group and
//           a multi-cycle shift-add unsigned multiplier.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   CW     iteration-counter width, derived from WIDTH (leave at default)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while busy = 0
//   op_sel   in   [1:0] group: 00 shift/mul, 01 logic, 10 add, 11 sub
//   opcode   in   [3:0] sub-operation within the group
//   opA/opB  in   [WIDTH-1:0] operands, captured on the accepted start
//   busy     out  high while a multiply is iterating (FSM is in MUL)
//   done     out  one-cycle pulse when res/flags update
//   res      out  [WIDTH-1:0] registered result, held until next completion
//   Z,C,O,N  out  registered flags, updated together with res
//
// Handshake: a start seen at a rising edge while busy = 0 is accepted at
// that edge. Single-cycle operations complete at the same edge (done high
// for the following cycle); MUL raises busy at that edge and completes WIDTH
// edges later. A start while busy = 1 is dropped, never queued. A start in
// the cycle done is high is accepted, so single-cycle ops can issue every
// cycle.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             Z,
  output logic             C,
  output logic             O,
  output logic             N
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_OPND = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    W_CNT  = CW'(WIDTH);
  localparam logic [CW-1:0]    ONE_CNT = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, shifts left
  logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, shifts right
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // partial-product accumulator
  logic [CW-1:0]        cnt_q, cnt_d;       // iterations remaining
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;
  logic                 o_q, o_d;
  logic                 n_q, n_d;
  logic                 done_q, done_d;

  // -------------------------------------------------------------------------
  // Single-cycle result path
  // -------------------------------------------------------------------------
  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     diff_w;
  logic                 shamt_big;
  logic [WIDTH-1:0]     rot_amt;
  logic [2*WIDTH-1:0]   rot_w;
  logic [WIDTH-1:0]     sra_w;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_o;
  logic                 is_mul;

  always_comb begin
    sum_w     = {1'b0, opA} + {1'b0, opB};
    diff_w    = opA - opB;
    shamt_big = (opB >= W_OPND);
    rot_amt   = opB % W_OPND;
    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    rot_w     = {opA, opA} << rot_amt;
    sra_w     = $unsigned($signed(opA) >>> opB);
    is_mul    = (op_sel == 2'b00) && (opcode == 4'd5);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;

    unique case (op_sel)
      2'b01: begin
        unique case (opcode)
          4'd1:    alu_res = ~opA;
          4'd2:    alu_res = opA & opB;
          4'd3:    alu_res = opA | opB;
          4'd4:    alu_res = ~(opA & opB);
          4'd5:    alu_res = ~(opA | opB);
          4'd6:    alu_res = opA ^ opB;
          4'd7:    alu_res = ~(opA ^ opB);
          default: alu_res = '0;
        endcase
      end
      2'b10: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_o   = (opA[MSB] == opB[MSB]) && (sum_w[MSB] != opA[MSB]);
      end
      2'b11: begin
        alu_res = diff_w;
        alu_c   = (opA < opB);
        alu_o   = (opA[MSB] != opB[MSB]) && (diff_w[MSB] != opA[MSB]);
      end
      default: begin
        unique case (opcode)
          4'd1:    alu_res = shamt_big ? '0 : (opA << opB);
          4'd2:    alu_res = shamt_big ? '0 : (opA >> opB);
          4'd3:    alu_res = shamt_big ? {WIDTH{opA[MSB]}} : sra_w;
          4'd4:    alu_res = rot_w[2*WIDTH-1:WIDTH];
          default: alu_res = '0;  // MUL never completes through this path
        endcase
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Multiplier step: accumulator value after this cycle's iteration
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] acc_step;
  logic               prod_hi_nz;

  always_comb begin
    acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_hi_nz = |acc_step[2*WIDTH-1:WIDTH];
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    z_d      = z_q;
    c_d      = c_q;
    o_d      = o_q;
    n_d      = n_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, opA};
            mplier_d = opB;
            acc_d    = '0;
            cnt_d    = W_CNT;
            state_d  = S_MUL;
          end else begin
            res_d  = alu_res;
            z_d    = (alu_res == '0);
            n_d    = alu_res[MSB];
            c_d    = alu_c;
            o_d    = alu_o;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - ONE_CNT;
        // Last iteration: the result comes from this cycle's accumulation.
        if (cnt_q == ONE_CNT) begin
          res_d   = acc_step[WIDTH-1:0];
          z_d     = (acc_step[WIDTH-1:0] == '0);
          n_d     = acc_step[MSB];
          c_d     = prod_hi_nz;
          o_d     = prod_hi_nz;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      o_q      <= 1'b0;
      n_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      z_q      <= z_d;
      c_q      <= c_d;
      o_q      <= o_d;
      n_q      <= n_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == S_MUL);
  assign done = done_q;
  assign res  = res_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign O    = o_q;
  assign N    = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : drives a WIDTH=4 and a WIDTH=8 instance of alu_seq with the
// same operation stream (the 4-bit instance sees the low operand nibbles)
// and checks handshake timing and results against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic [3:0] opcode = 4'd0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;

  logic       busy4, done4, z4, c4, o4, n4;
  logic [3:0] res4;
  logic       busy8, done8, z8, c8, o8, n8;
  logic [7:0] res8;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .opcode(opcode),
    .opA(op_a[3:0]), .opB(op_b[3:0]), .busy(busy4), .done(done4), .res(res4),
    .Z(z4), .C(c4), .O(o4), .N(n4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel), .opcode(opcode),
    .opA(op_a), .opB(op_b), .busy(busy8), .done(done8), .res(res8),
    .Z(z8), .C(c8), .O(o8), .N(n8)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {N,O,C,Z,res[7:0]} per completion, per instance
  logic [11:0] exp4_q[$];
  logic [11:0] exp8_q[$];

  function automatic logic [11:0] obs4();
    return {n4, o4, c4, z4, 4'h0, res4};
  endfunction

  function automatic logic [11:0] obs8();
    return {n8, o8, c8, z8, res8};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: plain integer arithmetic at width w
  // -------------------------------------------------------------------------
  function automatic logic [11:0] model(input logic [1:0] sel, input logic [3:0] opc,
                                        input logic [7:0] a_in, input logic [7:0] b_in,
                                        input int w);
    longint m, a, b, sa, sb, r, full, p, lim, k;
    logic z, c, o, n;
    logic [7:0] r8;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    a   = longint'(a_in) & m;
    b   = longint'(b_in) & m;
    sa  = (a >= lim) ? a - (m + 1) : a;
    sb  = (b >= lim) ? b - (m + 1) : b;
    r = 0; c = 1'b0; o = 1'b0;
    case (sel)
      2'b01: begin
        case (opc)
          4'd1: r = ~a & m;
          4'd2: r = a & b;
          4'd3: r = a | b;
          4'd4: r = ~(a & b) & m;
          4'd5: r = ~(a | b) & m;
          4'd6: r = a ^ b;
          4'd7: r = ~(a ^ b) & m;
          default: r = 0;
        endcase
      end
      2'b10: begin
        full = a + b;
        r = full & m;
        c = (full > m);
        o = ((sa + sb) >= lim) || ((sa + sb) < -lim);
      end
      2'b11: begin
        r = (a - b) & m;
        c = (a < b);
        o = ((sa - sb) >= lim) || ((sa - sb) < -lim);
      end
      default: begin
        case (opc)
          4'd1: r = (b >= w) ? 0 : ((a << b) & m);
          4'd2: r = (b >= w) ? 0 : (a >> b);
          4'd3: r = ((b >= w) ? (sa >>> (w - 1)) : (sa >>> b)) & m;
          4'd4: begin
            k = b % w;
            r = ((a << k) | (a >> (w - k))) & m;
          end
          4'd5: begin
            p = a * b;
            r = p & m;
            c = ((p >> w) != 0);
            o = c;
          end
          default: r = 0;
        endcase
      end
    endcase
    r8 = r[7:0];
    z  = (r == 0);
    n  = r[w-1];
    return {n, o, c, z, r8};
  endfunction

  // -------------------------------------------------------------------------
  // Driver: issue one op, then follow both instances for 10 edges checking
  // done/busy timing, the completion result and that it is held afterwards.
  // inject = 1 raises an ADD 1+1 start at edge k+2, which must be ignored.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic [1:0] sel, input logic [3:0] opc,
                        input logic [7:0] a, input logic [7:0] b, input bit inject);
    bit is_mul;
    int de4, de8;
    logic [11:0] held4, held8;
    string t;
    is_mul = (sel == 2'b00) && (opc == 4'd5);
    de4 = is_mul ? 4 : 0;
    de8 = is_mul ? 8 : 0;
    held4 = '0;
    held8 = '0;
    t = $sformatf("op%0d.%0d a=%h b=%h", sel, opc, a, b);
    exp4_q.push_back(model(sel, opc, a, b, 4));
    exp8_q.push_back(model(sel, opc, a, b, 8));
    @(negedge clk);
    op_sel = sel; opcode = opc; op_a = a; op_b = b; start = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk); #1;
      check($sformatf("done4 %s e%0d", t, e), done4, (e == de4));
      check($sformatf("busy4 %s e%0d", t, e), busy4, (is_mul && e < de4));
      check($sformatf("done8 %s e%0d", t, e), done8, (e == de8));
      check($sformatf("busy8 %s e%0d", t, e), busy8, (is_mul && e < de8));
      if (e == de4) begin
        if (exp4_q.size() == 0) check({"sb4 empty ", t}, 1, 0);
        else begin
          held4 = exp4_q.pop_front();
          check({"res4 ", t}, obs4(), held4);
        end
      end
      if (e == de4 + 1) check({"hold4 ", t}, obs4(), held4);
      if (e == de8) begin
        if (exp8_q.size() == 0) check({"sb8 empty ", t}, 1, 0);
        else begin
          held8 = exp8_q.pop_front();
          check({"res8 ", t}, obs8(), held8);
        end
      end
      if (e == de8 + 1) check({"hold8 ", t}, obs8(), held8);
      @(negedge clk);
      if (e == 0) begin
        start = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      if (inject && e == 1) begin
        start = 1'b1; op_sel = 2'b10; opcode = 4'd0; op_a = 8'h01; op_b = 8'h01;
      end
      if (inject && e == 2) start = 1'b0;
    end
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    // Reset state
    #12;
    check("reset res/flags4", obs4(), 12'h000);
    check("reset res/flags8", obs8(), 12'h000);
    check("reset busy/done4", {busy4, done4}, 2'b00);
    check("reset busy/done8", {busy8, done8}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b10, 4'd0, 8'h07, 8'h01, 1'b0);  // ADD 7+1
    run_op(2'b11, 4'd0, 8'h03, 8'h05, 1'b0);  // SUB 3-5
    run_op(2'b11, 4'd0, 8'h05, 8'h05, 1'b0);  // SUB 5-5
    run_op(2'b00, 4'd5, 8'h05, 8'h03, 1'b0);  // MUL 5x3
    run_op(2'b00, 4'd5, 8'h06, 8'h05, 1'b1);  // MUL 6x5, ignored start at k+2
    run_op(2'b00, 4'd3, 8'h08, 8'h01, 1'b0);  // SRA 8 by 1
    run_op(2'b00, 4'd2, 8'h08, 8'h05, 1'b0);  // SRL 8 by 5
    run_op(2'b00, 4'd4, 8'h09, 8'h05, 1'b0);  // ROL 9 by 5
    run_op(2'b00, 4'd1, 8'h81, 8'h09, 1'b0);  // SLL by >= WIDTH
    run_op(2'b00, 4'd3, 8'h90, 8'h0C, 1'b0);  // SRA by >= WIDTH
    run_op(2'b00, 4'd0, 8'h5A, 8'h01, 1'b0);  // group 00 opcode 0
    run_op(2'b01, 4'd0, 8'h5A, 8'h33, 1'b0);  // logic opcode 0
    run_op(2'b10, 4'd0, 8'hFF, 8'hFF, 1'b0);  // ADD FF+FF
    run_op(2'b00, 4'd5, 8'hFF, 8'hFF, 1'b0);  // MUL FFxFF

    // Back-to-back single-cycle ops: start held high across two edges
    exp4_q.push_back(model(2'b10, 4'd0, 8'h02, 8'h03, 4));
    exp8_q.push_back(model(2'b10, 4'd0, 8'h02, 8'h03, 8));
    exp4_q.push_back(model(2'b11, 4'd0, 8'h09, 8'h04, 4));
    exp8_q.push_back(model(2'b11, 4'd0, 8'h09, 8'h04, 8));
    @(negedge clk);
    op_sel = 2'b10; opcode = 4'd0; op_a = 8'h02; op_b = 8'h03; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b done4 %0d", i), done4, 1'b1);
      check($sformatf("b2b done8 %0d", i), done8, 1'b1);
      check($sformatf("b2b res4 %0d", i), obs4(), exp4_q.pop_front());
      check($sformatf("b2b res8 %0d", i), obs8(), exp8_q.pop_front());
      @(negedge clk);
      if (i == 0) begin
        op_sel = 2'b11; op_a = 8'h09; op_b = 8'h04;
      end else start = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b done4 end", done4, 1'b0);
    check("b2b done8 end", done8, 1'b0);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             8'($urandom), 8'($urandom), 1'b0);
    end
    run_op(2'b00, 4'd5, 8'($urandom_range(128, 255)), 8'($urandom_range(16, 255)), 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op_sel = 2'b00; opcode = 4'd5; op_a = 8'h37; op_b = 8'h2B; start = 1'b1;
    @(posedge clk); #1;
    check("mulrst busy4", busy4, 1'b1);
    check("mulrst busy8", busy8, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mulrst res/flags4", obs4(), 12'h000);
    check("mulrst res/flags8", obs8(), 12'h000);
    check("mulrst busy/done4", {busy4, done4}, 2'b00);
    check("mulrst busy/done8", {busy8, done8}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      check($sformatf("post-rst idle4 e%0d", e), {busy4, done4}, 2'b00);
      check($sformatf("post-rst idle8 e%0d", e), {busy8, done8}, 2'b00);
    end
    run_op(2'b10, 4'd0, 8'h4C, 8'h39, 1'b0);

    // Final report
    check("sb4 drained", exp4_q.size(), 0);
    check("sb8 drained", exp8_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 4-bit datapath ALU. It adds the following over that ALU:
- a start/done handshake;
- a shift/rotate group;
- a multi-cycle shift-add unsigned multiplier.

It sits between the register file and the accumulator/flag register. The microcode sequencer pulses `start` and waits on `done`, so single-cycle and multi-cycle operations share one control path.

## Interface
- `WIDTH`, default 4: operand/result width in bits; must be ≥ 2.
- `CW`, default `$clog2(WIDTH)+1`: iteration-counter width (derived; do not override).

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `busy`=0.
- `op_sel` input 2: 00 shift/mul group, 01 logic, 10 add, 11 sub.
- `opcode` input 4: sub-operation within the group.
- `opA`, `opB` input WIDTH: operands; captured on the accepted `start`.
- `busy` output 1: high while a multiply is iterating.
- `done` output 1: one-cycle pulse when `res`/flags update.
- `res` output WIDTH: registered result; held until the next completion.
- `Z`, `C`, `O`, `N` output 1 each: registered flags; updated together with `res`.

## Operation
- Logic group (`op_sel`=01), by opcode:
  - 1 NOT A, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
  - Other opcodes: `res`=0.
  - C=O=0.
- Add (`op_sel`=10):
  - {C,res} = opA+opB, computed at WIDTH+1 bits.
  - O = (A[MSB]==B[MSB]) && (res[MSB]!=A[MSB]).
- Sub (`op_sel`=11):
  - res = opA−opB mod 2^WIDTH.
  - C = borrow = (opA < opB) unsigned.
  - O = (A[MSB]!=B[MSB]) && (res[MSB]!=A[MSB]).
- Shift/mul group (`op_sel`=00); shift amount s = opB, taken as unsigned:
  - 1 SLL: s ≥ WIDTH gives 0.
  - 2 SRL: s ≥ WIDTH gives 0.
  - 3 SRA: s ≥ WIDTH gives all bits = A[MSB].
  - 4 ROL by s mod WIDTH.
  - 5 MUL: unsigned, multi-cycle. `res` = low WIDTH bits of A×B; C=O=1 iff the high WIDTH bits are nonzero.
  - Shifts/rotates: C=O=0.
  - Any other opcode, and `op_sel`=00/opcode 0: `res`=0, C=O=0.
- All operations: Z = (res==0), N = res[MSB].
- FSM states:
  - IDLE: on `start`=1, single-cycle ops register result/flags and pulse `done`, remaining in IDLE. MUL latches A into a multiplicand shift register and B into a multiplier shift register, clears the 2·WIDTH accumulator, sets counter = WIDTH, and goes to MUL.
  - MUL: each cycle, if multiplier LSB = 1, add the shifted multiplicand into the accumulator; shift the multiplicand left and the multiplier right; decrement the counter. On the cycle the counter reaches 0, load `res`/flags from the accumulator, pulse `done`, and return to IDLE.
- `start` while `busy`=1 is ignored: no queueing, and operands are not re-sampled.
- Operand inputs may change freely after acceptance.
- Reset (any state, any time): state=IDLE, `busy`=0, `done`=0, `res`=0, Z=C=O=N=0, counter and shift registers = 0. A multiply in progress is abandoned with no `done`.

## Timing
- `start` accepted at edge k, single-cycle op: `res`/flags valid and `done`=1 from edge k to edge k+1 (latency 1).
- `start` accepted at edge k, MUL:
  - `busy`=1 from edge k.
  - Iterations at edges k+1..k+WIDTH.
  - At edge k+WIDTH: `busy`→0, `res`/flags load, `done`=1 for one cycle. Latency WIDTH.
- `busy` is never high together with `done`.
- Back-to-back: a `start` in the cycle `done` is high is accepted, so single-cycle ops can issue every cycle.
- `res`/flags change only at edges where `done` rises, or at reset.

## Test plan
- WIDTH=4, ADD 0x7+0x1 → at k+1: `res`=0x8, N=1, O=1, C=0, Z=0, `done` pulse.
- SUB 0x3−0x5 → `res`=0xE, C=1, N=1, O=0. Then SUB 0x5−0x5 → `res`=0, Z=1, C=0.
- MUL 5×3 → `busy` high for 4 cycles; at k+4 `res`=0xF, C=O=0, `done` pulse.
- MUL 6×5 (product 30) → `res`=0xE, C=O=1, N=1. A second `start` (ADD 1+1) issued at k+2 is ignored; `res` stays 0xE after completion.
- SRA 0x8 by 1 → 0xC. SRL 0x8 by 5 → 0, Z=1. ROL 0x9 by 5 → 0x3. WIDTH=8 rerun of the ADD/MUL cases with 0xFF operands.
- Assert `rst_n`=0 at k+2 of a MUL → all outputs 0 immediately, no `done`. After release, a new ADD completes normally in 1 cycle.
